// File: rtl/vdp_host_if.sv
// VDP CPU port: control-byte pairing, auto-increment pointer, VRAM/palette/register writes, read-ahead fetch (req held until ack, 1-cycle issue), latched status/IRQ.
// Optional VDP_HOSTIF_WAIT_EN adds io_wait to stall data-port reads while a fetch is outstanding.
module vdp_host_if #(
    parameter int ADDR_W = 14,
    parameter int NSRC   = 4,
    parameter int PAL_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_portsel,
    input  logic [7:0]        io_wrdata,
    input  logic              io_wren,
    input  logic              io_wrdone,
    input  logic              io_rddone,
    output logic [7:0]        io_rddata,
`ifdef VDP_HOSTIF_WAIT_EN
    output logic              io_wait,
`endif
    output logic [ADDR_W-1:0] vram_wraddr,
    output logic [7:0]        vram_wrdata,
    output logic              vram_wren,
    output logic [ADDR_W-1:0] vram_rdaddr,
    output logic              vram_rdreq,
    input  logic              vram_rdack,
    input  logic [7:0]        vram_rddata,
    output logic [PAL_W-1:0]  pal_addr,
    output logic              pal_wren,
    output logic              reg_wr,
    output logic [3:0]        reg_idx,
    output logic [7:0]        reg_data,
    input  logic [NSRC-1:0]   src_pulse,
    input  logic [NSRC-1:0]   irq_en,
    output logic [NSRC-1:0]   status,
    output logic              irq
);

    localparam int PAD = 8 - NSRC;

    typedef enum logic {IDLE, REQ} fetch_st_t;

    fetch_st_t          state_q;
    logic [ADDR_W-1:0]  ptr_q, ptr_d, ptr_inc;
    logic [1:0]         code_q, code_d;
    logic               tgl_q, tgl_d;
    logic [7:0]         first_q, first_d;
    logic [7:0]         rbuf_q;
    logic [NSRC-1:0]    status_q, status_d;
    logic [ADDR_W-1:0]  rdaddr_q, pend_addr_q, sched_addr;
    logic               rdreq_q, pend_q, stale_q;
    logic               reg_wr_q;
    logic [3:0]         reg_idx_q;
    logic [7:0]         reg_data_q;
    logic               sched, reg_pulse;
    logic               ctrl_wr, data_wr, data_done, ctrl_rd_done;

    assign ctrl_wr      = io_wren & io_portsel;
    assign data_wr      = io_wren & ~io_portsel;
    assign data_done    = (io_wrdone | io_rddone) & ~io_portsel;
    assign ctrl_rd_done = io_rddone & io_portsel;
    assign ptr_inc      = ptr_q + ADDR_W'(1);

    always_comb begin
        ptr_d      = ptr_q;
        code_d     = code_q;
        tgl_d      = tgl_q;
        first_d    = first_q;
        sched      = 1'b0;
        sched_addr = ptr_q;
        reg_pulse  = 1'b0;
        if (ctrl_wr) begin
            tgl_d = ~tgl_q;
            if (!tgl_q) begin
                ptr_d[7:0] = io_wrdata;
                first_d    = io_wrdata;
            end else begin
                code_d               = io_wrdata[7:6];
                ptr_d[ADDR_W-1:8]    = io_wrdata[ADDR_W-9:0];
                sched                = (io_wrdata[7:6] == 2'd0);
                reg_pulse            = (io_wrdata[7:6] == 2'd2);
                sched_addr           = ptr_d;
            end
        end
        if (data_done) begin
            ptr_d = ptr_inc;
            tgl_d = 1'b0;
            if (io_rddone) begin
                sched      = 1'b1;
                sched_addr = ptr_inc;
            end
        end
        if (ctrl_rd_done) begin
            tgl_d = 1'b0;
        end
    end

    // A new source pulse outranks the read-clear in the same cycle.
    assign status_d = (status_q & ~{NSRC{ctrl_rd_done}}) | src_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            code_q   <= '0;
            tgl_q    <= 1'b0;
            first_q  <= '0;
            status_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            code_q   <= code_d;
            tgl_q    <= tgl_d;
            first_q  <= first_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rdaddr_q    <= '0;
            rdreq_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            stale_q     <= 1'b0;
            rbuf_q      <= '0;
            reg_wr_q    <= 1'b0;
            reg_idx_q   <= '0;
            reg_data_q  <= '0;
        end else begin
            reg_wr_q <= reg_pulse;
            if (reg_pulse) begin
                reg_idx_q  <= io_wrdata[3:0];
                reg_data_q <= first_q;
            end
            if (data_wr) begin
                rbuf_q <= io_wrdata;
            end
            case (state_q)
                IDLE: begin
                    if (sched) begin
                        rdaddr_q <= sched_addr;
                        rdreq_q  <= 1'b1;
                        stale_q  <= 1'b0;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (data_wr) begin
                        stale_q <= 1'b1;
                    end
                    if (sched) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= sched_addr;
                    end
                    if (vram_rdack) begin
                        // A superseded fetch returns nothing useful; chain straight into the newest target.
                        if (pend_q || sched) begin
                            rdaddr_q <= sched ? sched_addr : pend_addr_q;
                            pend_q   <= 1'b0;
                            stale_q  <= 1'b0;
                        end else begin
                            if (!stale_q && !data_wr) begin
                                rbuf_q <= vram_rddata;
                            end
                            rdreq_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_rddata   = io_portsel ? (8'(status_q) << PAD) : rbuf_q;
    assign vram_wraddr = ptr_q;
    assign vram_wrdata = io_wrdata;
    assign vram_wren   = data_wr & (code_q != 2'd3);
    assign pal_wren    = data_wr & (code_q == 2'd3);
    assign pal_addr    = ptr_q[PAL_W-1:0];
    assign vram_rdaddr = rdaddr_q;
    assign vram_rdreq  = rdreq_q;
    assign reg_wr      = reg_wr_q;
    assign reg_idx     = reg_idx_q;
    assign reg_data    = reg_data_q;
    assign status      = status_q;
    assign irq         = |(status_q & irq_en);

`ifdef VDP_HOSTIF_WAIT_EN
    assign io_wait = ((state_q == REQ) | pend_q) & ~io_portsel & ~io_wren;
`endif

endmodule

// File: tb/tb_vdp_host_if.sv
// Directed bench for vdp_host_if: cycle table for port sequencing/status, hand sequences for fetch overlap, wrap and reset.
module tb_vdp_host_if;

    localparam int OP_I  = 0;  // idle, data port selected
    localparam int OP_CW = 1;  // control write
    localparam int OP_DW = 2;  // data write
    localparam int OP_WD = 3;  // data write done
    localparam int OP_RD = 4;  // data read done
    localparam int OP_CR = 5;  // control read done
    localparam int OP_AK = 6;  // fetch ack with data
    localparam int OP_CI = 7;  // idle, control port selected

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_portsel = 1'b0;
    logic [7:0]  io_wrdata = '0;
    logic        io_wren = 1'b0, io_wrdone = 1'b0, io_rddone = 1'b0;
    logic [7:0]  io_rddata;
    logic [13:0] vram_wraddr, vram_rdaddr;
    logic [7:0]  vram_wrdata;
    logic        vram_wren, vram_rdreq;
    logic        vram_rdack = 1'b0;
    logic [7:0]  vram_rddata = '0;
    logic [4:0]  pal_addr;
    logic        pal_wren, reg_wr;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_data;
    logic [3:0]  src_pulse = '0, irq_en = '0, status;
    logic        irq;
`ifdef VDP_HOSTIF_WAIT_EN
    logic        io_wait;
`endif

    vdp_host_if #(.ADDR_W(14), .NSRC(4), .PAL_W(5)) dut (
        .clk(clk), .reset(reset),
        .io_portsel(io_portsel), .io_wrdata(io_wrdata), .io_wren(io_wren),
        .io_wrdone(io_wrdone), .io_rddone(io_rddone), .io_rddata(io_rddata),
`ifdef VDP_HOSTIF_WAIT_EN
        .io_wait(io_wait),
`endif
        .vram_wraddr(vram_wraddr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
        .vram_rdaddr(vram_rdaddr), .vram_rdreq(vram_rdreq), .vram_rdack(vram_rdack),
        .vram_rddata(vram_rddata), .pal_addr(pal_addr), .pal_wren(pal_wren),
        .reg_wr(reg_wr), .reg_idx(reg_idx), .reg_data(reg_data),
        .src_pulse(src_pulse), .irq_en(irq_en), .status(status), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op, d, src, ien;
        int wa, vw, pw, rd, rq, ra, rw, ri, rdt, st, irq;
    } vec_t;

    vec_t tbl[37];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int idx, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    // Present one cycle of stimulus; returns mid-cycle with inputs stable for sampling.
    task automatic cyc(input int op, input int d, input int src, input int ien);
        @(posedge clk);
        #1;
        io_portsel  = (op == OP_CW || op == OP_CR || op == OP_CI);
        io_wren     = (op == OP_CW || op == OP_DW);
        io_wrdone   = (op == OP_WD);
        io_rddone   = (op == OP_RD || op == OP_CR);
        vram_rdack  = (op == OP_AK);
        io_wrdata   = 8'(d);
        vram_rddata = 8'(d);
        src_pulse   = 4'(src);
        irq_en      = 4'(ien);
        #4;
    endtask

    initial begin
        //              op     d     src ien   wa       vw pw rd     rq ra      rw ri rdt    st irq
        tbl[0]  = '{OP_I,  'h00, 0, 0,  'h0000, 0, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[1]  = '{OP_CW, 'h34, 0, 0,  'h0000, 0, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[2]  = '{OP_CW, 'h52, 0, 0,  'h0034, 0, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[3]  = '{OP_DW, 'hAA, 0, 0,  'h1234, 1, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[4]  = '{OP_WD, 'h00, 0, 0,  'h1234, 0, 0, 'hAA, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[5]  = '{OP_DW, 'hBB, 0, 0,  'h1235, 1, 0, 'hAA, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[6]  = '{OP_WD, 'h00, 0, 0,  'h1235, 0, 0, 'hBB, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[7]  = '{OP_I,  'h00, 0, 0,  'h1236, 0, 0, 'hBB, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[8]  = '{OP_CW, 'h05, 0, 0,  'h1236, 0, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[9]  = '{OP_CW, 'hC0, 0, 0,  'h1205, 0, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[10] = '{OP_DW, 'h3C, 0, 0,  'h0005, 0, 1, 'hBB, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[11] = '{OP_WD, 'h00, 0, 0,  'h0005, 0, 0, 'h3C, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[12] = '{OP_CW, 'h00, 0, 0,  'h0006, 0, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[13] = '{OP_CW, 'h00, 0, 0,  'h0000, 0, 0, 'h00, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[14] = '{OP_I,  'h00, 0, 0,  'h0000, 0, 0, 'h3C, 1, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[15] = '{OP_AK, 'h5A, 0, 0,  'h0000, 0, 0, 'h3C, 1, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[16] = '{OP_RD, 'h00, 0, 0,  'h0000, 0, 0, 'h5A, 0, 'h0000, 0, 0, 'h00, 0, 0};
        tbl[17] = '{OP_I,  'h00, 0, 0,  'h0001, 0, 0, 'h5A, 1, 'h0001, 0, 0, 'h00, 0, 0};
        tbl[18] = '{OP_AK, 'hC3, 0, 0,  'h0001, 0, 0, 'h5A, 1, 'h0001, 0, 0, 'h00, 0, 0};
        tbl[19] = '{OP_CW, 'h1F, 0, 0,  'h0001, 0, 0, 'h00, 0, 'h0001, 0, 0, 'h00, 0, 0};
        tbl[20] = '{OP_CW, 'h81, 0, 0,  'h001F, 0, 0, 'h00, 0, 'h0001, 0, 0, 'h00, 0, 0};
        tbl[21] = '{OP_I,  'h00, 0, 0,  'h011F, 0, 0, 'hC3, 0, 'h0001, 1, 1, 'h1F, 0, 0};
        tbl[22] = '{OP_I,  'h00, 0, 0,  'h011F, 0, 0, 'hC3, 0, 'h0001, 0, 1, 'h1F, 0, 0};
        tbl[23] = '{OP_CW, 'h1F, 0, 0,  'h011F, 0, 0, 'h00, 0, 'h0001, 0, 1, 'h1F, 0, 0};
        tbl[24] = '{OP_CR, 'h00, 0, 0,  'h011F, 0, 0, 'h00, 0, 'h0001, 0, 1, 'h1F, 0, 0};
        tbl[25] = '{OP_CW, 'h40, 0, 0,  'h011F, 0, 0, 'h00, 0, 'h0001, 0, 1, 'h1F, 0, 0};
        tbl[26] = '{OP_I,  'h00, 0, 0,  'h0140, 0, 0, 'hC3, 0, 'h0001, 0, 1, 'h1F, 0, 0};
        tbl[27] = '{OP_I,  'h00, 1, 1,  'h0140, 0, 0, 'hC3, 0, 'h0001, 0, 1, 'h1F, 0, 0};
        tbl[28] = '{OP_CI, 'h00, 0, 1,  'h0140, 0, 0, 'h10, 0, 'h0001, 0, 1, 'h1F, 1, 1};
        tbl[29] = '{OP_CR, 'h00, 0, 1,  'h0140, 0, 0, 'h10, 0, 'h0001, 0, 1, 'h1F, 1, 1};
        tbl[30] = '{OP_CI, 'h00, 1, 1,  'h0140, 0, 0, 'h00, 0, 'h0001, 0, 1, 'h1F, 0, 0};
        tbl[31] = '{OP_CR, 'h00, 1, 1,  'h0140, 0, 0, 'h10, 0, 'h0001, 0, 1, 'h1F, 1, 1};
        tbl[32] = '{OP_CI, 'h00, 0, 1,  'h0140, 0, 0, 'h10, 0, 'h0001, 0, 1, 'h1F, 1, 1};
        tbl[33] = '{OP_CI, 'h00, 8, 0,  'h0140, 0, 0, 'h10, 0, 'h0001, 0, 1, 'h1F, 1, 0};
        tbl[34] = '{OP_CI, 'h00, 0, 8,  'h0140, 0, 0, 'h90, 0, 'h0001, 0, 1, 'h1F, 9, 1};
        tbl[35] = '{OP_CR, 'h00, 0, 8,  'h0140, 0, 0, 'h90, 0, 'h0001, 0, 1, 'h1F, 9, 1};
        tbl[36] = '{OP_CI, 'h00, 0, 0,  'h0140, 0, 0, 'h00, 0, 'h0001, 0, 1, 'h1F, 0, 0};

        #12 reset = 1'b0;

        for (int i = 0; i < 37; i++) begin
            cyc(tbl[i].op, tbl[i].d, tbl[i].src, tbl[i].ien);
            chk("wraddr",  i, int'(vram_wraddr), tbl[i].wa);
            chk("pal_addr", i, int'(pal_addr), tbl[i].wa % 32);
            chk("vram_wren", i, int'(vram_wren), tbl[i].vw);
            chk("pal_wren", i, int'(pal_wren), tbl[i].pw);
            chk("rddata",  i, int'(io_rddata), tbl[i].rd);
            chk("rdreq",   i, int'(vram_rdreq), tbl[i].rq);
            chk("rdaddr",  i, int'(vram_rdaddr), tbl[i].ra);
            chk("reg_wr",  i, int'(reg_wr), tbl[i].rw);
            chk("reg_idx", i, int'(reg_idx), tbl[i].ri);
            chk("reg_data", i, int'(reg_data), tbl[i].rdt);
            chk("status",  i, int'(status), tbl[i].st);
            chk("irq",     i, int'(irq), tbl[i].irq);
            if (tbl[i].vw == 1) chk("wrdata", i, int'(vram_wrdata), tbl[i].d);
        end

        // Overlapping reads: first fetch superseded, second targets pointer+2.
        cyc(OP_CW, 'h10, 0, 0);
        cyc(OP_CW, 'h40, 0, 0);
        cyc(OP_RD, 0, 0, 0);
        chk("ovl_wa", 100, int'(vram_wraddr), 'h0010);
        cyc(OP_RD, 0, 0, 0);
        chk("ovl_rq", 101, int'(vram_rdreq), 1);
        chk("ovl_ra", 101, int'(vram_rdaddr), 'h0011);
        for (int k = 0; k < 5; k++) begin
            cyc(OP_I, 0, 0, 0);
            chk("ovl_hold_rq", 102 + k, int'(vram_rdreq), 1);
            chk("ovl_hold_ra", 102 + k, int'(vram_rdaddr), 'h0011);
`ifdef VDP_HOSTIF_WAIT_EN
            chk("ovl_wait", 102 + k, int'(io_wait), 1);
`endif
        end
        cyc(OP_AK, 'hE1, 0, 0);
        cyc(OP_I, 0, 0, 0);
        chk("ovl_rq2", 110, int'(vram_rdreq), 1);
        chk("ovl_ra2", 110, int'(vram_rdaddr), 'h0012);
        chk("ovl_discard", 110, int'(io_rddata), 'hC3);
        cyc(OP_AK, 'hE2, 0, 0);
        cyc(OP_I, 0, 0, 0);
        chk("ovl_rq_done", 111, int'(vram_rdreq), 0);
        chk("ovl_buf", 111, int'(io_rddata), 'hE2);

        // Write during an outstanding fetch wins over the late ack.
        cyc(OP_RD, 0, 0, 0);
        cyc(OP_DW, 'h99, 0, 0);
        chk("stale_rq", 120, int'(vram_rdreq), 1);
        chk("stale_ra", 120, int'(vram_rdaddr), 'h0013);
        chk("stale_vw", 120, int'(vram_wren), 1);
        cyc(OP_AK, 'h11, 0, 0);
        cyc(OP_I, 0, 0, 0);
        chk("stale_buf", 121, int'(io_rddata), 'h99);
        chk("stale_rq0", 121, int'(vram_rdreq), 0);

        // Pointer wrap on write and on read.
        cyc(OP_CW, 'hFF, 0, 0);
        cyc(OP_CW, 'h7F, 0, 0);
        cyc(OP_DW, 'h77, 0, 0);
        chk("wrap_wa", 130, int'(vram_wraddr), 'h3FFF);
        chk("wrap_vw", 130, int'(vram_wren), 1);
        cyc(OP_WD, 0, 0, 0);
        cyc(OP_I, 0, 0, 0);
        chk("wrap_ptr", 131, int'(vram_wraddr), 'h0000);
        chk("wrap_buf", 131, int'(io_rddata), 'h77);
        cyc(OP_CW, 'hFF, 0, 0);
        cyc(OP_CW, 'h7F, 0, 0);
        cyc(OP_RD, 0, 1, 1);
        cyc(OP_I, 0, 0, 1);
        chk("wrapr_rq", 132, int'(vram_rdreq), 1);
        chk("wrapr_ra", 132, int'(vram_rdaddr), 'h0000);
        chk("wrapr_st", 132, int'(status), 1);
        chk("wrapr_irq", 132, int'(irq), 1);

        // Asynchronous reset while a fetch is outstanding.
        reset = 1'b1;
        #1;
        chk("rst_rq", 140, int'(vram_rdreq), 0);
        chk("rst_st", 140, int'(status), 0);
        chk("rst_irq", 140, int'(irq), 0);
        #2 reset = 1'b0;
        cyc(OP_AK, 'h66, 0, 0);
        cyc(OP_I, 0, 0, 0);
        chk("rst_ack_rq", 141, int'(vram_rdreq), 0);
        chk("rst_ack_buf", 141, int'(io_rddata), 'h00);
        chk("rst_wa", 141, int'(vram_wraddr), 'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vdp_host_if.md
Name: vdp_host_if

Overview:
- CPU-side register/port interface for the VDP family.
- Implements the two-byte control-port sequence, the auto-incrementing VRAM pointer, VRAM/palette write strobes and VDP register write pulses.
- Adds a true VRAM read-ahead buffer with a req/ack fetch handshake, and a parametrised bank of latched status/IRQ sources.
- Sits in the CPU clock domain between the I/O decoder and the VRAM/palette/register-sync logic.

Parameters:
ADDR_W, 14, VRAM address width; pointer wraps modulo 2^ADDR_W.
NSRC, 4, number of status/IRQ sources (1..8).
PAL_W, 5, palette address width; taken from low pointer bits.

Ports:
clk  in  1  CPU-domain clock
reset  in  1  asynchronous, active-high
io_portsel  in  1  0: data port, 1: control port
io_wrdata  in  8  CPU write data
io_wren  in  1  write strobe, one cycle
io_wrdone  in  1  end of CPU write cycle, one cycle
io_rddone  in  1  end of CPU read cycle, one cycle
io_rddata  out  8  combinational read data
vram_wraddr  out  ADDR_W  write address, equal to the pointer
vram_wrdata  out  8  equal to io_wrdata
vram_wren  out  1  VRAM write strobe
vram_rdaddr  out  ADDR_W  fetch address, registered
vram_rdreq  out  1  fetch request, held until ack
vram_rdack  in  1  one-cycle ack; vram_rddata valid in the same cycle
vram_rddata  in  8  fetched byte
pal_addr  out  PAL_W  pointer[PAL_W-1:0]
pal_wren  out  1  palette write strobe
reg_wr  out  1  register write pulse, one cycle
reg_idx  out  4  register index
reg_data  out  8  register data
src_pulse  in  NSRC  status set pulses, already synchronised to clk
irq_en  in  NSRC  per-source interrupt enable
status  out  NSRC  latched pending bits
irq  out  1  OR over (status & irq_en)

Behaviour:
- Reset values: all registered outputs 0; pointer 0; code 0; toggle 0; read buffer 0x00; FSM IDLE.
- Control write, toggle=0: pointer[7:0] <= byte.
- Control write, toggle=1:
  - code <= byte[7:6].
  - pointer[ADDR_W-1:8] <= byte[ADDR_W-9:0]; upper unused bits are ignored.
- Every control write flips the toggle.
- Second control byte, code 0: schedule a fetch at the new pointer.
- Second control byte, code 2: next cycle reg_wr=1, reg_idx=byte[3:0], reg_data=latched first byte. The pointer is still updated.
- Data write with code≠3: vram_wren=io_wren; address = current pointer.
- Data write with code=3: pal_wren instead.
- Every data write also loads the read buffer with io_wrdata.
- Data port read: io_rddata = read buffer.
- io_rddone or io_wrdone on the data port:
  - pointer += 1, with wrap;
  - toggle cleared;
  - after a data read, schedule a fetch at the incremented pointer.
- Control port read: io_rddata = {status, zero pad} MSB-aligned; bit 7 = source NSRC-1.
- io_rddone on the control port: toggle cleared; all status bits cleared.
- Status set/clear collision: set wins. A src_pulse in the same cycle as a clear leaves the bit at 1.
- Fetch FSM, IDLE:
  - On a schedule: REQ.
  - vram_rdaddr <= target address; vram_rdreq <= 1 on the next edge.
- Fetch FSM, REQ:
  - Hold vram_rdreq and vram_rdaddr stable.
  - On vram_rdack: buffer <= vram_rddata; rdreq <= 0; IDLE.
- Fetch latency: request visible 1 cycle after the trigger; buffer updated on the ack edge.
- Schedule arriving in REQ: the current request is kept and the new target is recorded as pending. On ack the returned data is discarded and a new request to the pending target starts on the next cycle (REQ→REQ). Only the latest pending target is kept.
- Data write during REQ: the write proceeds and loads the buffer. The outstanding ack then does not overwrite the buffer; the in-flight fetch is marked stale.
- Reset mid-fetch: rdreq drops asynchronously; any later ack is ignored in IDLE.
- Pointer wrap: 2^ADDR_W-1 + 1 = 0; the fetch targets 0.

Optional Feature:
- Macro: VDP_HOSTIF_WAIT_EN.
- Defined: adds output io_wait (1 bit). It is high combinationally while the FSM is in REQ, or a fetch is scheduled but not yet issued, and a data-port read is being presented. This lets the CPU wait-state until the buffer is fresh.
- Undefined: no io_wait port. Reads during a fetch return the previous buffer contents; the read still increments the pointer and reschedules.

Test Plan:
1. Control writes 0x34 then 0x52 (code 1) -> pointer 0x1234, no fetch; data writes 0xAA, 0xBB -> vram_wren at 0x1234 and 0x1235; pointer ends at 0x1236.
2. Control writes 0x00 then 0x00 (code 0) -> rdreq with rdaddr 0x0000; ack with 0x5A -> data read returns 0x5A, next rdreq with rdaddr 0x0001.
3. Control writes 0x1F then 0x81 -> one-cycle reg_wr with idx 1, data 0x1F; first byte 0x1F then a control read -> toggle cleared; next byte is treated as a low-address byte.
4. src_pulse[0]=1 with irq_en=0001 -> status[0]=1, irq=1; control read returns 0x10 (NSRC=4); rddone clears it; src_pulse in the same cycle as rddone -> bit stays 1.
5. Two data reads back-to-back with ack delayed 5 cycles -> first ack discarded, second fetch at the pointer +2 address; with VDP_HOSTIF_WAIT_EN, io_wait high throughout.
6. Pointer at 0x3FFF, data write 0x77 -> pointer 0x0000, buffer 0x77; reset asserted during REQ -> rdreq=0 immediately, status=0, irq=0.
